// File: rtl/alu_ops_pkg.sv
// Shared RV32I opcode/funct3 constants and the 4-bit ALU operation codes
// used by the alu_op_issue slice.
package alu_ops_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLTI = 4'b0011,
    ALU_BNE  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_SUB  = 4'b1010,
    ALU_ADDI = 4'b1011,
    ALU_SLT  = 4'b1100,
    ALU_BLT  = 4'b1101,
    ALU_SRL  = 4'b1110,
    ALU_BGE  = 4'b1111
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: instruction word -> ALU operation, branch flag,
// illegal flag. Illegal encodings report ADD; branch opcodes always flag is_branch.
module alu_op_decode
  import alu_ops_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     operation,
  output logic        is_branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7_5    = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    operation = ALU_ADD;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_ADD_SUB: operation = funct7_5 ? ALU_SUB : ALU_ADD;
          F3_AND:     operation = ALU_AND;
          F3_OR:      operation = ALU_OR;
          F3_XOR:     operation = ALU_XOR;
          F3_SLT:     operation = ALU_SLT;
          default:    illegal   = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3)
          F3_ADD_SUB: operation = ALU_ADDI;
          F3_SLT:     operation = ALU_SLTI;
          F3_SLL:     operation = ALU_SLL;
          F3_SR:      operation = funct7_5 ? ALU_SRA : ALU_SRL;
          F3_AND:     operation = ALU_AND;
          F3_OR:      operation = ALU_OR;
          F3_XOR:     operation = ALU_XOR;
          default:    illegal   = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  operation = ALU_EQ;
          F3_BNE:  operation = ALU_BNE;
          F3_BLT:  operation = ALU_BLT;
          F3_BGE:  operation = ALU_BGE;
          default: illegal   = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI, OPC_AUIPC: operation = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decoded-op issue stage: registered main entry plus one skid entry, with flush.
// Optional illegal-instruction statistics under ALU_OP_ISSUE_ILLEGAL_STATS_EN.
module alu_op_issue
  import alu_ops_pkg::*;
#(
  parameter int TAG_W         = 8,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] out_operation,
  output logic                     out_is_branch,
  output logic                     out_illegal,
  output logic [TAG_W-1:0]         out_tag
`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
  ,
  output logic [15:0]              illegal_count,
  output logic                     illegal_seen
`endif
);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic                     br;
    logic                     ill;
    logic [TAG_W-1:0]         tag;
  } entry_t;

  alu_op_t dec_op;
  logic    dec_br;
  logic    dec_ill;
  entry_t  new_entry;
  entry_t  main_q;
  entry_t  skid_q;
  logic    main_valid;
  logic    skid_valid;
  logic    ready_q;
  logic    accept;
  logic    consume;

  alu_op_decode u_decode (
    .instr     (in_instr),
    .operation (dec_op),
    .is_branch (dec_br),
    .illegal   (dec_ill)
  );

  assign new_entry = '{op: OPCODE_LENGTH'(dec_op), br: dec_br, ill: dec_ill, tag: in_tag};
  assign accept    = in_valid & ready_q;
  assign consume   = main_valid & out_ready;

  // ready_q tracks !skid_valid; accept with a full skid cannot occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (consume) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end else if (accept) begin
        main_q <= new_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_entry;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = main_valid;
  assign out_operation = main_q.op;
  assign out_is_branch = main_q.br;
  assign out_illegal   = main_q.ill;
  assign out_tag       = main_q.tag;

`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
      illegal_seen  <= 1'b0;
    end else if (accept && dec_ill && !flush) begin
      if (illegal_count != '1) illegal_count <= illegal_count + 16'd1;
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: directed scenarios plus a random stream
// compared against a table-driven decode and a queue model of the two-entry buffer.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_operation;
  logic        out_is_branch;
  logic        out_illegal;
  logic [7:0]  out_tag;
`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
  logic [15:0] illegal_count;
  logic        illegal_seen;
`endif

  alu_op_issue #(.TAG_W(8), .OPCODE_LENGTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_tag        (in_tag),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operation (out_operation),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal),
    .out_tag       (out_tag)
`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
    ,
    .illegal_count (illegal_count),
    .illegal_seen  (illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic       br;
    logic       ill;
    logic [7:0] tag;
  } exp_t;

  // key {opcode, funct3, funct7[5]} -> {is_branch, op}; absent key = illegal
  logic [4:0] dec_tbl [bit [10:0]];
  exp_t       mq[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [15:0] m_count = '0;
  logic        m_seen  = 1'b0;

  function automatic void add(input logic [6:0] opc, input logic [2:0] f3,
                              input int f7, input logic br, input logic [3:0] op);
    for (int b = 0; b < 2; b++)
      if (f7 < 0 || f7 == b) dec_tbl[{opc, f3, b[0]}] = {br, op};
  endfunction

  function automatic void build_table();
    logic [6:0] addops [5];
    addops = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111, 7'b0010111};
    add(7'b0110011, 3'b000, 0, 1'b0, 4'b0010);
    add(7'b0110011, 3'b000, 1, 1'b0, 4'b1010);
    add(7'b0110011, 3'b111, -1, 1'b0, 4'b0000);
    add(7'b0110011, 3'b110, -1, 1'b0, 4'b0101);
    add(7'b0110011, 3'b100, -1, 1'b0, 4'b0001);
    add(7'b0110011, 3'b010, -1, 1'b0, 4'b1100);
    add(7'b0010011, 3'b000, -1, 1'b0, 4'b1011);
    add(7'b0010011, 3'b010, -1, 1'b0, 4'b0011);
    add(7'b0010011, 3'b001, -1, 1'b0, 4'b0110);
    add(7'b0010011, 3'b101, 0, 1'b0, 4'b1110);
    add(7'b0010011, 3'b101, 1, 1'b0, 4'b0111);
    add(7'b0010011, 3'b111, -1, 1'b0, 4'b0000);
    add(7'b0010011, 3'b110, -1, 1'b0, 4'b0101);
    add(7'b0010011, 3'b100, -1, 1'b0, 4'b0001);
    add(7'b1100011, 3'b000, -1, 1'b1, 4'b1000);
    add(7'b1100011, 3'b001, -1, 1'b1, 4'b0100);
    add(7'b1100011, 3'b100, -1, 1'b1, 4'b1101);
    add(7'b1100011, 3'b101, -1, 1'b1, 4'b1111);
    foreach (addops[i])
      for (int f = 0; f < 8; f++) add(addops[i], f[2:0], -1, 1'b0, 4'b0010);
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [7:0] tg);
    exp_t e;
    bit [10:0] key;
    key   = {ins[6:0], ins[14:12], ins[30]};
    e.tag = tg;
    if (dec_tbl.exists(key)) begin
      e.br  = dec_tbl[key][4];
      e.op  = dec_tbl[key][3:0];
      e.ill = 1'b0;
    end else begin
      e.br  = (ins[6:0] == 7'b1100011);
      e.op  = 4'b0010;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic compare();
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      check("out_operation", {28'd0, out_operation}, {28'd0, mq[0].op});
      check("out_is_branch", {31'd0, out_is_branch}, {31'd0, mq[0].br});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, mq[0].ill});
      check("out_tag", {24'd0, out_tag}, {24'd0, mq[0].tag});
    end
`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
    check("illegal_count", {16'd0, illegal_count}, {16'd0, m_count});
    check("illegal_seen", {31'd0, illegal_seen}, {31'd0, m_seen});
`endif
  endtask

  // Called at a negedge: drive, advance one clock, update model, compare.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                       input logic fl, input logic ordy);
    logic acc, con;
    exp_t e;
    in_valid = v; in_instr = ins; in_tag = tg; flush = fl; out_ready = ordy;
    acc = v && (mq.size() < 2);
    con = ordy && (mq.size() > 0);
    e   = ref_decode(ins, tg);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (con) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (e.ill) begin
          if (m_count != 16'hFFFF) m_count++;
          m_seen = 1'b1;
        end
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_out_operation"}, {28'd0, out_operation}, 32'd0);
    check({name, "_out_is_branch"}, {31'd0, out_is_branch}, 32'd0);
    check({name, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
    check({name, "_out_tag"}, {24'd0, out_tag}, 32'd0);
  endtask

  initial begin
    logic [6:0]  opcs [9];
    logic [31:0] ins;
    opcs = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    build_table();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single SUB
    cycle(1'b1, 32'h40B50533, 8'h11, 1'b0, 1'b1);
    check("sub_op", {28'd0, out_operation}, 32'b1010);
    check("sub_tag", {24'd0, out_tag}, 32'h11);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

    // Back-to-back stream
    cycle(1'b1, 32'h00B50533, 8'h20, 1'b0, 1'b1);
    check("stream0_op", {28'd0, out_operation}, 32'b0010);
    cycle(1'b1, 32'h40355513, 8'h21, 1'b0, 1'b1);
    check("stream1_op", {28'd0, out_operation}, 32'b0111);
    cycle(1'b1, 32'h00B55463, 8'h22, 1'b0, 1'b1);
    check("stream2_br", {31'd0, out_is_branch}, 32'd1);
    cycle(1'b1, 32'h00052503, 8'h23, 1'b0, 1'b1);
    check("stream3_br", {31'd0, out_is_branch}, 32'd0);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

    // Stall: three offered, two taken, outputs frozen on the first
    cycle(1'b1, 32'h00B50533, 8'h30, 1'b0, 1'b0);
    cycle(1'b1, 32'h40B50533, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 32'h00052503, 8'h32, 1'b0, 1'b0);
    check("stall_tag", {24'd0, out_tag}, 32'h30);
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    check("drain_tag", {24'd0, out_tag}, 32'h31);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    check("drain_ready", {31'd0, in_ready}, 32'd1);

    // Flush with both entries full and input offered
    cycle(1'b1, 32'h00B50533, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B50533, 8'h41, 1'b0, 1'b0);
    cycle(1'b1, 32'h00355513, 8'h42, 1'b1, 1'b0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stall
    cycle(1'b1, 32'h00B50533, 8'h50, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B50533, 8'h51, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    in_valid = 1'b0;
    mq.delete(); m_count = '0; m_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare();

    // Illegal encodings
    cycle(1'b1, 32'h0000007F, 8'h60, 1'b0, 1'b1);
    check("illegal_opc", {31'd0, out_illegal}, 32'd1);
    check("illegal_opc_op", {28'd0, out_operation}, 32'b0010);
    cycle(1'b1, 32'h00001033, 8'h61, 1'b0, 1'b1);
    check("illegal_f3", {31'd0, out_illegal}, 32'd1);
`ifdef ALU_OP_ISSUE_ILLEGAL_STATS_EN
    check("illegal_count_2", {16'd0, illegal_count}, 32'd2);
    check("illegal_seen_1", {31'd0, illegal_seen}, 32'd1);
`endif
    cycle(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);

    // Random stream against the model
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 8)];
      cycle($urandom_range(0, 9) < 7, ins, 8'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
